pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the monocycle core.
- Holds the current PC and selects the next value. Priority: trap vector > redirect target > sequential increment.
- Rejects misaligned redirect targets with a registered fault pulse.
- Counts taken redirects; optionally includes a return-address stack (RAS).
- Sits between the control unit, branch/jump resolution and instruction memory.

Parameters:
- XLEN, 32, address width.
- RESET_VECTOR, 0, PC value loaded on reset (XLEN bits).
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero (1 for compressed ISA).
- CNT_W, 16, width of the redirect counter.
- RAS_DEPTH, 4, RAS entries (power of two, ≥2); used only with the macro.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_write  in  1  advance enable; 0 = stall
- redirect_valid  in  1  redirect request this cycle
- redirect_kind  in  2  0 = jump/branch, 1 = call, 2 = return, 3 = treated as 0
- redirect_target  in  XLEN  redirect address
- trap_valid  in  1  trap request; overrides stall and redirect
- trap_vector  in  XLEN  trap handler address
- pc_out  out  XLEN  current PC (registered)
- pc_next  out  XLEN  combinational value pc_out will take at the next edge
- misalign_fault  out  1  one-cycle pulse: redirect rejected
- misalign_addr  out  XLEN  last rejected target
- redirect_count  out  CNT_W  saturating count of accepted redirects
- ras_top  out  XLEN  RAS top entry (0 when disabled or empty)
- ras_valid  out  1  RAS non-empty (0 when disabled)

Behaviour:
- Reset (async, any time, including mid-stall or mid-fault):
  - pc_out = RESET_VECTOR; misalign_fault = 0; misalign_addr = 0; redirect_count = 0.
  - RAS emptied.
  - First post-reset edge behaves as a normal cycle.
- Per rising edge, evaluated in priority order:
  1. trap_valid = 1: pc_out <= trap_vector with low ALIGN_BITS forced to 0. Applies regardless of pc_write. Any redirect that cycle is dropped; the RAS is untouched; redirect_count is unchanged.
  2. pc_write = 0: pc_out holds. redirect_valid is ignored and not remembered.
  3. redirect_valid = 1 and target low ALIGN_BITS ≠ 0:
     - pc_out holds.
     - Next cycle: misalign_fault = 1, misalign_addr = target.
     - RAS and redirect_count unchanged.
  4. redirect_valid = 1, aligned: pc_out <= redirect_target; redirect_count += 1, saturating at all-ones.
  5. Otherwise: pc_out <= pc_out + INC, modulo 2^XLEN (0xFFFFFFFC + 4 = 0x00000000 at XLEN = 32).
- misalign_fault is high only on the cycle after a rejection; it re-asserts on back-to-back rejections. misalign_addr holds until the next rejection.
- pc_next mirrors the selection above: equals pc_out when stalled or rejected, 0-latency combinational.
- No internal state machine beyond the PC register, fault flag, counter and RAS pointer; single-cycle latency from request to pc_out.

Optional Feature:
- Macro: PC_SEQUENCER_RAS_EN.
- Enabled: circular RAS of RAS_DEPTH entries, updated only on accepted redirects (case 4):
  - call (kind 1): push pc_out + INC.
  - return (kind 2): pop.
  - Push when full overwrites the oldest entry; occupancy stays RAS_DEPTH.
  - Pop when empty is ignored; ras_valid stays 0.
  - ras_top/ras_valid are registered and reflect the post-update state.
- Disabled: no RAS storage; redirect_kind is ignored; ras_top = 0 and ras_valid = 0 constantly.

Test Plan:
- Reset, then 3 cycles with pc_write = 1 -> pc_out 0x0, 0x4, 0x8, 0xC; redirect_count = 0.
- Reset asserted mid-sequence at pc_out = 0x40 -> pc_out = RESET_VECTOR immediately (async), fault and count cleared.
- pc_write = 0 with redirect_valid = 1, target 0x100 -> pc_out holds; after the stall, the next pc_write gives pc_out + 4 (no 0x100).
- Aligned redirect to 0x200, then misaligned 0x202 -> pc_out = 0x200 and count = 1; then pc_out stays 0x200, misalign_fault pulses 1 for exactly one cycle, misalign_addr = 0x202, count stays 1.
- trap_valid = 1, trap_vector = 0x80000003, pc_write = 0, redirect_valid = 1 -> pc_out = 0x80000000; count unchanged. Separately, pc_out = 0xFFFFFFFC with sequential advance -> wraps to 0x0.
- With PC_SEQUENCER_RAS_EN, RAS_DEPTH = 4:
  - 5 calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_top = 0x54.
  - 4 returns -> ras_top sequence 0x44, 0x34, 0x24; ras_valid = 0 after the 4th (0x14 overwritten).
  - A 5th return is ignored.
  - Without the macro -> ras_valid = 0 throughout.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle between the control/branch side
// (master) and the program counter sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             pc_write;
  logic             redirect_valid;
  logic [1:0]       redirect_kind;
  logic [XLEN-1:0]  redirect_target;
  logic             trap_valid;
  logic [XLEN-1:0]  trap_vector;
  logic [XLEN-1:0]  pc_out;
  logic [XLEN-1:0]  pc_next;
  logic             misalign_fault;
  logic [XLEN-1:0]  misalign_addr;
  logic [CNT_W-1:0] redirect_count;
  logic [XLEN-1:0]  ras_top;
  logic             ras_valid;

  modport master (
    output pc_write, redirect_valid, redirect_kind, redirect_target,
           trap_valid, trap_vector,
    input  pc_out, pc_next, misalign_fault, misalign_addr, redirect_count,
           ras_top, ras_valid
  );

  modport slave (
    input  pc_write, redirect_valid, redirect_kind, redirect_target,
           trap_valid, trap_vector,
    output pc_out, pc_next, misalign_fault, misalign_addr, redirect_count,
           ras_top, ras_valid
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register selecting trap > redirect > sequential, with misaligned
// redirect fault and saturating redirect counter. PC_SEQUENCER_RAS_EN adds a return-address stack.
module pc_sequencer #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2,
  parameter int unsigned     CNT_W        = 16,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [1:0]      KIND_CALL  = 2'd1;
  localparam logic [1:0]      KIND_RET   = 2'd2;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  seq_pc_c;
  logic             misalign_c;
  logic             accept_c;

  // Next-PC selection; a rejected or stalled cycle keeps the current PC.
  always_comb begin
    seq_pc_c   = pc_q + XLEN'(INC);
    misalign_c = (bus.redirect_target & ALIGN_MASK) != '0;
    accept_c   = 1'b0;
    pc_d       = pc_q;
    fault_d    = 1'b0;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    if (bus.trap_valid) begin
      pc_d = bus.trap_vector & ~ALIGN_MASK;
    end else if (bus.pc_write) begin
      if (bus.redirect_valid && misalign_c) begin
        fault_d = 1'b1;
        addr_d  = bus.redirect_target;
      end else if (bus.redirect_valid) begin
        accept_c = 1'b1;
        pc_d     = bus.redirect_target;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        pc_d = seq_pc_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_out         = pc_q;
  assign bus.pc_next        = pc_d;
  assign bus.misalign_fault = fault_q;
  assign bus.misalign_addr  = addr_q;
  assign bus.redirect_count = cnt_q;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [XLEN-1:0]  ras_top_q, ras_top_d;
  logic             ras_valid_q;
  logic             push_c, pop_c;

  // Circular stack: wr_ptr points one past the top; a full push overwrites the oldest slot.
  always_comb begin
    push_c    = accept_c && (bus.redirect_kind == KIND_CALL);
    pop_c     = accept_c && (bus.redirect_kind == KIND_RET) && (occ_q != '0);
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    ras_top_d = ras_top_q;
    if (push_c) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      occ_d     = (occ_q == OCC_W'(RAS_DEPTH)) ? occ_q : occ_q + OCC_W'(1);
      ras_top_d = seq_pc_c;
    end else if (pop_c) begin
      wr_ptr_d  = wr_ptr_q - PTR_W'(1);
      occ_d     = occ_q - OCC_W'(1);
      ras_top_d = (occ_q == OCC_W'(1)) ? '0 : ras_mem_q[wr_ptr_q - PTR_W'(2)];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      ras_top_q   <= '0;
      ras_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      ras_top_q   <= ras_top_d;
      ras_valid_q <= (occ_d != '0);
    end
  end

  // Entry contents need no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_c) begin
      ras_mem_q[wr_ptr_q] <= seq_pc_c;
    end
  end

  assign bus.ras_top   = ras_top_q;
  assign bus.ras_valid = ras_valid_q;
`else
  logic unused_ras_cfg;

  assign unused_ras_cfg = ^{bus.redirect_kind, accept_c, (RAS_DEPTH > 1),
                            KIND_CALL, KIND_RET};
  assign bus.ras_top    = '0;
  assign bus.ras_valid  = 1'b0;
`endif

endmodule
